// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : sdram_port_arbiter
// Three-requester Avalon arbiter feeding one SDRAM master, with in-order
// read-return routing through a tag FIFO.
// Rev    : 1.0
// ============================================================================

module sdram_port_arbiter #(
   parameter int MAX_OUTSTANDING = 8,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [25:0] r0_address,
   input  logic        r0_read,
   input  logic        r0_write,
   input  logic [3:0]  r0_byteenable,
   input  logic [31:0] r0_writedata,
   output logic        r0_waitrequest,
   output logic [31:0] r0_readdata,
   output logic        r0_readdatavalid,
   input  logic [25:0] r1_address,
   input  logic        r1_read,
   input  logic        r1_write,
   input  logic [3:0]  r1_byteenable,
   input  logic [31:0] r1_writedata,
   output logic        r1_waitrequest,
   output logic [31:0] r1_readdata,
   output logic        r1_readdatavalid,
   input  logic [25:0] r2_address,
   input  logic        r2_read,
   input  logic        r2_write,
   input  logic [3:0]  r2_byteenable,
   input  logic [31:0] r2_writedata,
   output logic        r2_waitrequest,
   output logic [31:0] r2_readdata,
   output logic        r2_readdatavalid,
   output logic [25:0] m_address,
   output logic        m_read,
   output logic        m_write,
   output logic [3:0]  m_byteenable,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        m_readdatavalid,
   input  logic        m_waitrequest,
   output logic        err_unexpected_rd
);

   localparam int c_CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int c_PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int c_SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [c_CW-1:0] c_MAX_CNT    = c_CW'(MAX_OUTSTANDING);
   localparam logic [c_PW-1:0] c_PTR_LAST   = c_PW'(MAX_OUTSTANDING - 1);
   localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

   state_t          r_state;
   logic [1:0]      r_tag [MAX_OUTSTANDING];
   logic [c_PW-1:0] r_wptr, r_rptr;
   logic [c_CW-1:0] r_count;
   logic [c_SW-1:0] r_starve;
   logic            r_rr_r2;

   logic [2:0]  w_rd, w_req, w_elig, w_gnt;
   logic        w_rd_ok, w_can, w_other, w_any, w_gnt_rd, w_push, w_pop;
   logic [1:0]  w_gnt_id, w_head;
   logic [25:0] w_sel_addr;
   logic [3:0]  w_sel_be;
   logic [31:0] w_sel_wd;

   function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
      return (p == c_PTR_LAST) ? '0 : p + c_PW'(1);
   endfunction

   // A read issued while both strobes are high is a read.
   assign w_rd    = {r2_read, r1_read, r0_read};
   assign w_req   = w_rd | {r2_write, r1_write, r0_write};
   assign w_rd_ok = (r_count < c_MAX_CNT);
   assign w_elig  = w_req & (~w_rd | {3{w_rd_ok}});
   assign w_can   = reset && ((r_state == ST_IDLE) || !m_waitrequest);
   assign w_other = w_elig[1] | w_elig[2];

   always_comb begin
      w_gnt = 3'b000;
      if (w_can) begin
         if (w_elig[0] && !((r_starve == c_STARVE_MAX) && w_other)) w_gnt = 3'b001;
         else if (w_elig[1] && w_elig[2]) w_gnt = r_rr_r2 ? 3'b100 : 3'b010;
         else if (w_elig[1]) w_gnt = 3'b010;
         else if (w_elig[2]) w_gnt = 3'b100;
      end
   end

   assign w_any    = |w_gnt;
   assign w_gnt_rd = |(w_gnt & w_rd);
   assign w_gnt_id = w_gnt[2] ? 2'd2 : (w_gnt[1] ? 2'd1 : 2'd0);
   assign w_push   = w_any && w_gnt_rd;
   assign w_pop    = m_readdatavalid && (r_count != '0);
   assign w_head   = r_tag[r_rptr];

   assign r0_waitrequest = ~w_gnt[0];
   assign r1_waitrequest = ~w_gnt[1];
   assign r2_waitrequest = ~w_gnt[2];

   always_comb begin
      w_sel_addr = r0_address;
      w_sel_be   = r0_byteenable;
      w_sel_wd   = r0_writedata;
      if (w_gnt[1]) begin
         w_sel_addr = r1_address;
         w_sel_be   = r1_byteenable;
         w_sel_wd   = r1_writedata;
      end else if (w_gnt[2]) begin
         w_sel_addr = r2_address;
         w_sel_be   = r2_byteenable;
         w_sel_wd   = r2_writedata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
         m_address    <= '0;
         m_byteenable <= '0;
         m_writedata  <= '0;
      end else if (w_any) begin
         r_state      <= ST_ISSUE;
         m_read       <= w_gnt_rd;
         m_write      <= ~w_gnt_rd;
         m_address    <= w_sel_addr;
         m_byteenable <= w_sel_be;
         m_writedata  <= w_sel_wd;
      end else if ((r_state == ST_ISSUE) && !m_waitrequest) begin
         r_state      <= ST_IDLE;
         m_read       <= 1'b0;
         m_write      <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_tag[r_wptr] <= w_gnt_id;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wptr            <= '0;
         r_rptr            <= '0;
         r_count           <= '0;
         r_starve          <= '0;
         r_rr_r2           <= 1'b0;
         r0_readdatavalid  <= 1'b0;
         r1_readdatavalid  <= 1'b0;
         r2_readdatavalid  <= 1'b0;
         r0_readdata       <= '0;
         r1_readdata       <= '0;
         r2_readdata       <= '0;
         err_unexpected_rd <= 1'b0;
      end else begin
         if (w_push) r_wptr <= f_next(r_wptr);
         if (w_pop)  r_rptr <= f_next(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CW'(1);
            2'b01:   r_count <= r_count - c_CW'(1);
            default: r_count <= r_count;
         endcase

         if (w_gnt[1] || w_gnt[2])        r_starve <= '0;
         else if (!(w_req[1] || w_req[2])) r_starve <= '0;
         else if (w_gnt[0] && w_other)     r_starve <= r_starve + c_SW'(1);

         if (w_gnt[1])      r_rr_r2 <= 1'b1;
         else if (w_gnt[2]) r_rr_r2 <= 1'b0;

         r0_readdatavalid <= w_pop && (w_head == 2'd0);
         r1_readdatavalid <= w_pop && (w_head == 2'd1);
         r2_readdatavalid <= w_pop && (w_head == 2'd2);
         if (w_pop && (w_head == 2'd0)) r0_readdata <= m_readdata;
         if (w_pop && (w_head == 2'd1)) r1_readdata <= m_readdata;
         if (w_pop && (w_head == 2'd2)) r2_readdata <= m_readdata;

         // Returns with nothing in flight (e.g. after a reset) are dropped.
         if (m_readdatavalid && (r_count == '0)) err_unexpected_rd <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_sdram_port_arbiter
// Directed and randomized bench for sdram_port_arbiter against a queue model.
// Rev    : 1.0
// ============================================================================

module tb_sdram_port_arbiter;

   localparam int MAX_OUT = 8;
   localparam int STARVE  = 4;

   logic              clock;
   logic              reset;
   logic [2:0][25:0]  t_addr;
   logic [2:0]        t_rd, t_wr, t_wait, t_rv;
   logic [2:0][3:0]   t_be;
   logic [2:0][31:0]  t_wd, t_rdat;
   logic [25:0]       m_address;
   logic              m_read, m_write;
   logic [3:0]        m_byteenable;
   logic [31:0]       m_writedata, m_readdata;
   logic              m_readdatavalid, m_waitrequest, err_unexpected_rd;

   sdram_port_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(STARVE)) dut (
      .clock(clock), .reset(reset),
      .r0_address(t_addr[0]), .r0_read(t_rd[0]), .r0_write(t_wr[0]),
      .r0_byteenable(t_be[0]), .r0_writedata(t_wd[0]), .r0_waitrequest(t_wait[0]),
      .r0_readdata(t_rdat[0]), .r0_readdatavalid(t_rv[0]),
      .r1_address(t_addr[1]), .r1_read(t_rd[1]), .r1_write(t_wr[1]),
      .r1_byteenable(t_be[1]), .r1_writedata(t_wd[1]), .r1_waitrequest(t_wait[1]),
      .r1_readdata(t_rdat[1]), .r1_readdatavalid(t_rv[1]),
      .r2_address(t_addr[2]), .r2_read(t_rd[2]), .r2_write(t_wr[2]),
      .r2_byteenable(t_be[2]), .r2_writedata(t_wd[2]), .r2_waitrequest(t_wait[2]),
      .r2_readdata(t_rdat[2]), .r2_readdatavalid(t_rv[2]),
      .m_address(m_address), .m_read(m_read), .m_write(m_write),
      .m_byteenable(m_byteenable), .m_writedata(m_writedata),
      .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
      .m_waitrequest(m_waitrequest), .err_unexpected_rd(err_unexpected_rd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: command slot, tag queue in issue order, arbitration state.
   int          mdl_tags[$];
   bit          mdl_issue, mdl_cmd_rd, mdl_err;
   logic [25:0] mdl_addr;
   logic [3:0]  mdl_be;
   logic [31:0] mdl_wd;
   int          mdl_starve, mdl_rr;
   bit          mdl_rv[3];
   logic [31:0] mdl_rdat[3];
   int          sd_pend, last_win;
   bit          obs_wait[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mdl_tags.delete();
      mdl_issue  = 0;
      mdl_cmd_rd = 0;
      mdl_err    = 0;
      mdl_starve = 0;
      mdl_rr     = 1;
      for (int i = 0; i < 3; i++) mdl_rv[i] = 0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      chk("rst_m_read", m_read, 0);
      chk("rst_m_write", m_write, 0);
      chk("rst_m_address", m_address, 0);
      chk("rst_m_byteenable", m_byteenable, 0);
      chk("rst_m_writedata", m_writedata, 0);
      chk("rst_err", err_unexpected_rd, 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_wait%0d", i), t_wait[i], 1);
         chk($sformatf("rst_rvalid%0d", i), t_rv[i], 0);
         chk($sformatf("rst_rdata%0d", i), t_rdat[i], 0);
      end
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // One clock: check DUT against model, advance model, step to posedge+1.
   task automatic cycle();
      int win;
      bit can, r12;
      bit e[3];
      #2;
      can = !mdl_issue || !m_waitrequest;
      for (int i = 0; i < 3; i++)
         e[i] = (t_rd[i] || t_wr[i]) && (!t_rd[i] || (mdl_tags.size() < MAX_OUT));
      win = -1;
      if (can) begin
         if (e[0] && !(mdl_starve == STARVE && (e[1] || e[2]))) win = 0;
         else if (e[1] && e[2]) win = mdl_rr;
         else if (e[1]) win = 1;
         else if (e[2]) win = 2;
      end
      last_win = win;
      for (int i = 0; i < 3; i++) begin
         obs_wait[i] = t_wait[i];
         chk($sformatf("waitrequest%0d", i), t_wait[i], (win != i));
         chk($sformatf("rvalid%0d", i), t_rv[i], mdl_rv[i]);
         if (mdl_rv[i]) chk($sformatf("rdata%0d", i), t_rdat[i], mdl_rdat[i]);
      end
      chk("m_read", m_read, mdl_issue && mdl_cmd_rd);
      chk("m_write", m_write, mdl_issue && !mdl_cmd_rd);
      if (mdl_issue) begin
         chk("m_address", m_address, mdl_addr);
         chk("m_byteenable", m_byteenable, mdl_be);
         if (!mdl_cmd_rd) chk("m_writedata", m_writedata, mdl_wd);
      end
      chk("err_unexpected_rd", err_unexpected_rd, mdl_err);

      for (int i = 0; i < 3; i++) mdl_rv[i] = 0;
      if (m_readdatavalid) begin
         if (mdl_tags.size() > 0) begin
            int o;
            o = mdl_tags.pop_front();
            mdl_rv[o]   = 1;
            mdl_rdat[o] = m_readdata;
         end else begin
            mdl_err = 1;
         end
      end
      r12 = t_rd[1] || t_wr[1] || t_rd[2] || t_wr[2];
      if (win == 1 || win == 2) mdl_starve = 0;
      else if (!r12) mdl_starve = 0;
      else if (win == 0 && (e[1] || e[2])) mdl_starve++;
      if (win == 1) mdl_rr = 2;
      else if (win == 2) mdl_rr = 1;
      if (mdl_issue && mdl_cmd_rd && !m_waitrequest) sd_pend++;
      if (win >= 0) begin
         if (t_rd[win]) mdl_tags.push_back(win);
         mdl_issue  = 1;
         mdl_cmd_rd = t_rd[win];
         mdl_addr   = t_addr[win];
         mdl_be     = t_be[win];
         mdl_wd     = t_wd[win];
      end else if (mdl_issue && !m_waitrequest) begin
         mdl_issue = 0;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic set_cmd(input int i, input bit rd, input bit wr, input logic [25:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
      t_rd[i] = rd; t_wr[i] = wr; t_addr[i] = a; t_be[i] = be; t_wd[i] = wd;
   endtask

   task automatic clr(input int i);
      t_rd[i] = 1'b0;
      t_wr[i] = 1'b0;
   endtask

   int exp_ord[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
   int g, op;

   initial begin
      reset = 1'b1;
      t_addr = '0; t_rd = '0; t_wr = '0; t_be = '0; t_wd = '0;
      m_readdata = '0; m_readdatavalid = 1'b0; m_waitrequest = 1'b0;
      sd_pend = 0; last_win = -1;
      #1;
      set_cmd(0, 0, 1, 26'h1, 4'hF, 32'h1);
      do_reset();
      clr(0);

      // Single read from r1, returned three cycles after the grant.
      set_cmd(1, 1, 0, 26'h0000100, 4'hF, 32'h0);
      cycle();
      chk("t1_grant", obs_wait[1], 0);
      clr(1);
      chk("t1_mread_n1", m_read, 1);
      chk("t1_addr_n1", m_address, 26'h0000100);
      cycle();
      chk("t1_mread_n2", m_read, 0);
      cycle();
      m_readdata = 32'hDEADBEEF; m_readdatavalid = 1'b1;
      cycle();
      m_readdatavalid = 1'b0;
      chk("t1_r1_valid", t_rv[1], 1);
      chk("t1_r1_data", t_rdat[1], 32'hDEADBEEF);
      chk("t1_r0_valid", t_rv[0], 0);
      chk("t1_r2_valid", t_rv[2], 0);
      cycle();

      // r2 write under five cycles of backpressure while r0/r1 wait.
      set_cmd(2, 0, 1, 26'h2ABCDEF, 4'b0110, 32'hCAFE1234);
      cycle();
      clr(2);
      set_cmd(0, 0, 1, 26'h10, 4'hF, 32'h0);
      set_cmd(1, 0, 1, 26'h11, 4'hF, 32'h1);
      for (int k = 0; k < 6; k++) begin
         m_waitrequest = (k < 5);
         chk("t2_m_write", m_write, 1);
         chk("t2_m_address", m_address, 26'h2ABCDEF);
         chk("t2_m_writedata", m_writedata, 32'hCAFE1234);
         chk("t2_m_byteenable", m_byteenable, 4'b0110);
         cycle();
         if (k < 5) begin
            chk("t2_r0_held", obs_wait[0], 1);
            chk("t2_r1_held", obs_wait[1], 1);
         end
      end
      m_waitrequest = 1'b0;
      clr(0);
      cycle();
      clr(1);
      cycle();

      // Starvation: all three request continuously.
      do_reset();
      set_cmd(0, 0, 1, 26'h100, 4'hF, 32'hA);
      set_cmd(1, 0, 1, 26'h200, 4'hF, 32'hB);
      set_cmd(2, 0, 1, 26'h300, 4'hF, 32'hC);
      for (int k = 0; k < 10; k++) begin
         cycle();
         g = !obs_wait[0] ? 0 : (!obs_wait[1] ? 1 : (!obs_wait[2] ? 2 : 3));
         chk($sformatf("t3_order%0d", k), g, exp_ord[k]);
      end
      clr(0); clr(1); clr(2);
      cycle();

      // Outstanding limit: eight reads in flight hold the ninth.
      do_reset();
      t_rd[1] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         t_addr[1] = 26'(k);
         cycle();
         chk("t4_read_grant", obs_wait[1], 0);
      end
      t_addr[1] = 26'h8;
      set_cmd(2, 0, 1, 26'h3FF, 4'h3, 32'h55AA55AA);
      cycle();
      chk("t4_r1_held", obs_wait[1], 1);
      chk("t4_r2_write_granted", obs_wait[2], 0);
      clr(2);
      m_readdata = 32'h11110000; m_readdatavalid = 1'b1;
      cycle();
      m_readdatavalid = 1'b0;
      chk("t4_r1_held_at_return", obs_wait[1], 1);
      chk("t4_first_return", t_rv[1], 1);
      cycle();
      chk("t4_released", obs_wait[1], 0);
      clr(1);
      for (int k = 0; k < 8; k++) begin
         m_readdata = 32'h22220000 + 32'(k); m_readdatavalid = 1'b1;
         cycle();
      end
      m_readdatavalid = 1'b0;
      cycle();

      // Interleaved reads r0,r1,r0,r1 with grant/return overlap.
      set_cmd(0, 1, 0, 26'h10, 4'hF, 32'h0);
      cycle(); clr(0);
      set_cmd(1, 1, 0, 26'h20, 4'hF, 32'h0);
      cycle(); clr(1);
      set_cmd(0, 1, 0, 26'h30, 4'hF, 32'h0);
      m_readdata = 32'hA0A0A0A0; m_readdatavalid = 1'b1;
      cycle(); clr(0);
      chk("t5_ret0_r0", t_rv[0], 1);
      chk("t5_ret0_data", t_rdat[0], 32'hA0A0A0A0);
      set_cmd(1, 1, 0, 26'h40, 4'hF, 32'h0);
      m_readdata = 32'hB1B1B1B1;
      cycle(); clr(1);
      chk("t5_ret1_r1", t_rv[1], 1);
      chk("t5_ret1_not_r0", t_rv[0], 0);
      m_readdata = 32'hC2C2C2C2;
      cycle();
      chk("t5_ret2_r0", t_rv[0], 1);
      chk("t5_ret2_data", t_rdat[0], 32'hC2C2C2C2);
      m_readdata = 32'hD3D3D3D3;
      cycle();
      chk("t5_ret3_r1", t_rv[1], 1);
      chk("t5_ret3_data", t_rdat[1], 32'hD3D3D3D3);
      m_readdatavalid = 1'b0;
      cycle();
      chk("t5_no_err", err_unexpected_rd, 0);

      // Reset with three reads outstanding, then their stale returns.
      t_rd[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         t_addr[2] = 26'h100 + 26'(k);
         cycle();
      end
      clr(2);
      cycle();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         m_readdata = 32'h0BAD0000 + 32'(k); m_readdatavalid = 1'b1;
         cycle();
         for (int i = 0; i < 3; i++) chk($sformatf("t6_stale_rv%0d", i), t_rv[i], 0);
      end
      m_readdatavalid = 1'b0;
      cycle();
      chk("t6_err_set", err_unexpected_rd, 1);

      // Randomized traffic with a responder returning accepted reads.
      do_reset();
      sd_pend = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < 3; i++) begin
            if (!(t_rd[i] || t_wr[i]) && $urandom_range(0, 1) == 1) begin
               op = $urandom_range(0, 3);
               set_cmd(i, (op != 1), (op == 1 || op == 2), 26'($urandom),
                       4'($urandom), $urandom);
            end
         end
         m_waitrequest = ($urandom_range(0, 2) == 0);
         m_readdata = $urandom;
         if (sd_pend > 0 && $urandom_range(0, 3) == 0) begin
            m_readdatavalid = 1'b1;
            sd_pend--;
         end else begin
            m_readdatavalid = 1'b0;
         end
         cycle();
         if (last_win >= 0) clr(last_win);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8: maximum number of reads in flight at the SDRAM, including any read held in the command register.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: number of consecutive r0 grants allowed while r1 or r2 is waiting.
REQ-003 SHALL have port clock, input, 1: clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have, for each i in 0..2, port r<i>_address, input, 26: requester word address.
REQ-006 SHALL have r<i>_read, input, 1, and r<i>_write, input, 1: requester command strobes.
REQ-007 SHALL have r<i>_byteenable, input, 4, and r<i>_writedata, input, 32.
REQ-008 SHALL have r<i>_waitrequest, output, 1: command not accepted this cycle.
REQ-009 SHALL have r<i>_readdata, output, 32, and r<i>_readdatavalid, output, 1: routed read return.
REQ-010 SHALL have m_address, output, 26; m_read, output, 1; m_write, output, 1; m_byteenable, output, 4; m_writedata, output, 32: Avalon master to SDRAM.
REQ-011 SHALL have m_readdata, input, 32; m_readdatavalid, input, 1; m_waitrequest, input, 1.
REQ-012 SHALL have err_unexpected_rd, output, 1: sticky flag, readdatavalid received with no read outstanding.

Function
REQ-013 Requester roles SHALL be: r0 display scan-out (highest priority), r1 depth fetch, r2 depth/color write-back.
REQ-014 SHALL hold exactly one command register (address, byteenable, writedata, read/write, owner); m_* outputs SHALL be driven directly from it.
REQ-015 Register state SHALL be IDLE (m_read=m_write=0) or ISSUE (m_read or m_write =1, all m_* held stable); ISSUE->IDLE on a clock edge with m_waitrequest=0.
REQ-016 A grant SHALL be allowed in a cycle when state is IDLE, or when state is ISSUE with m_waitrequest=0 (back-to-back issue, no bubble).
REQ-017 A read request SHALL be eligible only if the outstanding count is < MAX_OUTSTANDING; a write request SHALL always be eligible.
REQ-018 If r<i>_read and r<i>_write are both asserted, the command SHALL be treated as a read.
REQ-019 Among eligible requesters, r0 SHALL win unless the starvation counter equals STARVE_LIMIT and r1 or r2 is eligible; otherwise r1 vs r2 SHALL be decided by a round-robin pointer, which toggles to the other requester after each r1/r2 grant (r1 first after reset).
REQ-020 The starvation counter SHALL increment on each r0 grant made while r1 or r2 is eligible, clear on any r1/r2 grant, and clear when neither r1 nor r2 requests.
REQ-021 r<i>_waitrequest SHALL be combinational: 0 only in the cycle requester i is granted, 1 otherwise (including when idle).
REQ-022 Latency: a command granted in cycle N SHALL appear on m_* in cycle N+1.
REQ-023 On a read grant, the owner ID SHALL be pushed into a tag FIFO of depth MAX_OUTSTANDING, and the outstanding count SHALL increment.
REQ-024 On m_readdatavalid=1 with the FIFO non-empty, the head SHALL be popped and the count decremented; in cycle +1, r<owner>_readdatavalid SHALL be 1 with m_readdata on r<owner>_readdata.
REQ-025 A simultaneous read grant and return SHALL leave the count unchanged, with the FIFO pushing and popping in the same cycle.
REQ-026 m_readdatavalid with an empty FIFO SHALL be discarded, raise no requester valid, and set err_unexpected_rd.
REQ-027 Read returns SHALL be routed strictly in issue order; writes SHALL not touch the FIFO.

Reset
REQ-028 reset=0 SHALL immediately clear: state IDLE, m_read=0, m_write=0, m_address=0, m_byteenable=0, m_writedata=0, all r<i>_readdatavalid=0, r<i>_readdata=0, r<i>_waitrequest=1, outstanding count=0, tag FIFO empty, starvation counter=0, round-robin pointer=r1, err_unexpected_rd=0.
REQ-029 Returns arriving after a mid-operation reset SHALL be handled per REQ-026.

Verification
REQ-030 Single read: r1 reads 0x0000100 with m_waitrequest=0 and data 0xDEADBEEF returned 3 cycles later -> m_read for 1 cycle at N+1; r1_readdatavalid=1 with 0xDEADBEEF one cycle after the return; r0/r2 valid stay 0.
REQ-031 Backpressure: m_waitrequest=1 for 5 cycles during an r2 write -> m_address, m_writedata, m_byteenable, m_write stable for all 6 cycles; r0/r1 waitrequest remain 1.
REQ-032 Starvation: r0, r1, r2 all requesting continuously -> grant order r0,r0,r0,r0,r1,r0,r0,r0,r0,r2,...
REQ-033 Outstanding limit: r1 issues 8 reads with no return -> 9th read held (r1_waitrequest=1) while an r2 write is still granted; first return releases the 9th read next cycle.
REQ-034 Interleaved returns: reads issued r0,r1,r0,r1 -> returns route to r0,r1,r0,r1; a grant and a return in the same cycle keep the count correct.
REQ-035 Reset with 3 reads outstanding, then 3 returns -> no requester valid; err_unexpected_rd=1.
